// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus: instruction-memory port, redirect, and the instruction output
interface fetch_ctrl_if #(
    parameter int PC_WIDTH = 10
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                stall;
    logic                inst_valid;
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch with a 2-entry buffer and redirect squash
module fetch_ctrl #(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] BOOT_PC  = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FULL} state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [PC_WIDTH-1:0] r_inflight, w_inflight_nxt;
    logic                r_squash, w_squash_nxt;
    logic [31:0]         r_word  [2];
    logic [PC_WIDTH-1:0] r_waddr [2];
    logic                r_head;
    logic [1:0]          r_count;
    logic                w_push, w_pop, w_flush, w_tail;

    assign w_flush = bus.redirect;
    assign w_tail  = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= BOOT_PC;
            r_inflight <= '0;
            r_squash   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inflight <= w_inflight_nxt;
            r_squash   <= w_squash_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inflight_nxt = r_inflight;
        w_squash_nxt   = r_squash;
        w_push         = 1'b0;
        w_pop          = (r_count != 2'd0) && !bus.stall && !bus.redirect;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (bus.redirect) w_pc_nxt = bus.redirect_pc;
            end
            S_REQ: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (bus.imem_gnt) begin
                        w_squash_nxt = 1'b1;
                        w_state_nxt  = S_RESP;
                    end
                end else if (bus.imem_gnt) begin
                    w_inflight_nxt = r_pc;
                    w_pc_nxt       = r_pc + PC_WIDTH'(1);
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (bus.imem_rvalid) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_squash_nxt = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_push = 1'b1;
                        // count is at most 1 here, so after the push it stays below 2 only with a pop or from empty
                        w_state_nxt = (w_pop || r_count == 2'd0) ? S_REQ : S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (bus.redirect) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (w_pop) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_word[0]  <= '0;
            r_word[1]  <= '0;
            r_waddr[0] <= '0;
            r_waddr[1] <= '0;
        end else if (w_flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            if (w_push) begin
                r_word[w_tail]  <= bus.imem_rdata;
                r_waddr[w_tail] <= r_inflight;
            end
            if (w_pop) r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.imem_req   = (r_state == S_REQ);
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = (r_count != 2'd0);
    assign bus.inst       = r_word[r_head];
    assign bus.inst_pc    = r_waddr[r_head];
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 10, width of all program-counter and instruction-address signals.
REQ-002 Parameter BOOT_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  PC_WIDTH  word address of requested instruction.
REQ-007 imem_gnt  input  1  memory accepts request this cycle (valid only with imem_req=1).
REQ-008 imem_rvalid  input  1  read data valid for the oldest accepted request.
REQ-009 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-010 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-011 redirect_pc  input  PC_WIDTH  new fetch address.
REQ-012 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-013 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-014 inst  output  32  instruction word at buffer head.
REQ-015 inst_pc  output  PC_WIDTH  address of inst.

Function
REQ-016 Internal fetch PC register; increments by 1 (word addressing) per granted request, wrapping modulo 2^PC_WIDTH.
REQ-017 Internal 2-entry FIFO of {instruction, address}; inst_valid = (count != 0); inst/inst_pc driven combinationally from head.
REQ-018 Pop occurs when inst_valid=1 and stall=0; push occurs on accepted (non-squashed) imem_rvalid; simultaneous push and pop leaves count unchanged.
REQ-019 At most one request outstanding; FSM states IDLE, REQ, RESP, FULL.
REQ-020 IDLE: imem_req=0; next state REQ unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=PC; on imem_gnt: record address as in-flight, PC<=PC+1, go RESP; else stay, address held stable.
REQ-022 RESP: imem_req=0; on imem_rvalid push word with in-flight address; go REQ if post-update count <2, else FULL.
REQ-023 FULL: imem_req=0; go REQ on the cycle a pop occurs.
REQ-024 Request latency: first imem_req exactly 2 cycles after rst deasserts; back-to-back fetch throughput 1 instruction per 2 cycles with single-cycle gnt and rvalid.
REQ-025 redirect has priority over every other event: PC<=redirect_pc, FIFO flushed (count=0, inst_valid=0 next cycle), any same-cycle pop ignored.
REQ-026 redirect in REQ without gnt: stay REQ, imem_addr=redirect_pc next cycle (only permitted address change while req pending).
REQ-027 redirect in REQ with gnt, or in RESP without rvalid: set squash flag, go/stay RESP; the next imem_rvalid is discarded, squash cleared, go REQ.
REQ-028 redirect in RESP coincident with imem_rvalid: response discarded, go REQ, squash stays 0.
REQ-029 redirect in IDLE or FULL: go REQ with PC=redirect_pc.
REQ-030 imem_rvalid in any state other than RESP is ignored.

Reset
REQ-031 On rst: state IDLE, PC=BOOT_PC, count=0, squash=0, FIFO storage cleared; outputs imem_req=0, imem_addr=BOOT_PC, inst_valid=0, inst=0, inst_pc=0.
REQ-032 rst mid-transaction abandons the outstanding request; a late imem_rvalid after reset is ignored per REQ-030.

Verification
REQ-033 Reset release, gnt/rvalid always 1, stall=0 -> imem_addr 0,1,2,3 on successive requests; inst_pc sequence 0,1,2,3 with matching inst.
REQ-034 stall=1 held -> exactly 2 instructions buffered (pc 0,1), FSM in FULL, imem_req=0; drop stall one cycle -> pc 0 popped, request for address 2 issued next cycle.
REQ-035 redirect to 0x100 while in RESP, rvalid 3 cycles later with 0xDEADBEEF -> word discarded, next imem_addr=0x100, first inst_pc=0x100.
REQ-036 PC_WIDTH=10, redirect_pc=0x3FF -> fetches 0x3FF then 0x000.
REQ-037 gnt held 0 for 5 cycles -> imem_req=1 and imem_addr constant throughout; redirect and pop same cycle with count=2 -> inst_valid=0 next cycle, nothing delivered.
REQ-038 rst asserted while in RESP, rvalid arrives during IDLE -> inst_valid stays 0, first fetch again at BOOT_PC.
